// File: rtl/router_pkg.sv
// Shared constants and header decoding for the router packet FIFO.
// Module parameter defaults live here; pkt_len works on any byte width up to HDR_MAX_W.
package router_pkg;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_AF_THRESH = 14;
  localparam int PTR_W         = $clog2(DEF_DEPTH);
  localparam int LEN_LSB       = 2;
  localparam int HDR_MAX_W     = 32;

  // Callers zero-extend the header in and size-cast the result down to their length width.
  function automatic logic [HDR_MAX_W-1:0] pkt_len(input logic [HDR_MAX_W-1:0] hdr);
    return hdr >> LEN_LSB;
  endfunction
endpackage

// File: rtl/router_pkt_tracker.sv
// Packet boundary tracker: a header loads len+1 remaining bytes, other strobes count down.
// Latency: o_last is combinational in the strobe cycle; no backpressure, it follows accepted ops only.
module router_pkt_tracker #(
  parameter int LEN_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_strobe,
  input  logic             i_is_hdr,
  input  logic [LEN_W-1:0] i_len,
  output logic [LEN_W:0]   o_rem,
  output logic             o_last
);
  localparam logic [LEN_W:0] REM_ONE = {{LEN_W{1'b0}}, 1'b1};

  logic [LEN_W:0] r_rem;

  assign o_rem  = r_rem;
  assign o_last = i_strobe && !i_is_hdr && (r_rem == REM_ONE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rem <= '0;
    end else if (i_strobe) begin
      // A header always restarts the count, abandoning any packet in progress.
      if (i_is_hdr) begin
        r_rem <= {1'b0, i_len} + REM_ONE;
      end else if (r_rem != '0) begin
        r_rem <= r_rem - REM_ONE;
      end
    end
  end
endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware output FIFO for one router port, entries tagged with a start-of-packet bit.
// Latency: read data one cycle after read_enb; backpressure: writes dropped when full (sticky overflow), reads ignored when empty.
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEF_AF_THRESH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     soft_reset,
  input  logic                     write_enb,
  input  logic                     lfd_state,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     read_enb,
  output logic [DATA_W-1:0]        data_out,
  output logic                     out_valid,
  output logic                     sop,
  output logic                     eop,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   pkt_count,
  output logic                     overflow
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int LEN_W = DATA_W - LEN_LSB;

  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] AF_LVL  = CW'(AF_THRESH);

  logic [DATA_W:0]     r_mem [DEPTH];
  logic [AW:0]         r_wr_ptr;
  logic [AW:0]         r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       r_pkt_count;
  logic [DATA_W-1:0]   r_data_out;
  logic                r_out_valid;
  logic                r_sop;
  logic                r_eop;
  logic                r_overflow;

  logic                w_rst;
  logic                w_full;
  logic                w_empty;
  logic                w_wr_acc;
  logic                w_rd_acc;
  logic [DATA_W:0]     w_rd_entry;
  logic [LEN_W-1:0]    w_wr_len;
  logic [LEN_W-1:0]    w_rd_len;
  logic                w_wr_last;
  logic                w_rd_last;
  logic [LEN_W:0]      w_unused_wr_rem;
  logic [LEN_W:0]      w_unused_rd_rem;

  assign w_rst      = reset || soft_reset;
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_wr_acc   = write_enb && !w_full;
  assign w_rd_acc   = read_enb && !w_empty;
  assign w_rd_entry = r_mem[r_rd_ptr[AW-1:0]];
  assign w_wr_len   = LEN_W'(pkt_len(HDR_MAX_W'(data_in)));
  assign w_rd_len   = LEN_W'(pkt_len(HDR_MAX_W'(w_rd_entry[DATA_W-1:0])));

  router_pkt_tracker #(.LEN_W(LEN_W)) u_wr_trk (
    .i_clk    (clock),
    .i_rst    (w_rst),
    .i_strobe (w_wr_acc),
    .i_is_hdr (lfd_state),
    .i_len    (w_wr_len),
    .o_rem    (w_unused_wr_rem),
    .o_last   (w_wr_last)
  );

  router_pkt_tracker #(.LEN_W(LEN_W)) u_rd_trk (
    .i_clk    (clock),
    .i_rst    (w_rst),
    .i_strobe (w_rd_acc),
    .i_is_hdr (w_rd_entry[DATA_W]),
    .i_len    (w_rd_len),
    .o_rem    (w_unused_rd_rem),
    .o_last   (w_rd_last)
  );

  // Storage is deliberately not cleared on reset; the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  always_ff @(posedge clock) begin
    if (w_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pkt_count <= '0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
      r_sop       <= 1'b0;
      r_eop       <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count <= r_count + CW'(w_wr_acc) - CW'(w_rd_acc);

      // Idle read cycles drive zeros so downstream never sees stale bytes.
      r_data_out  <= w_rd_acc ? w_rd_entry[DATA_W-1:0] : '0;
      r_out_valid <= w_rd_acc;
      r_sop       <= w_rd_acc && w_rd_entry[DATA_W];
      r_eop       <= w_rd_last;

      if (write_enb && w_full) begin
        r_overflow <= 1'b1;
      end

      if (w_wr_last && !w_rd_last) begin
        r_pkt_count <= r_pkt_count + PTR_ONE;
      end else if (w_rd_last && !w_wr_last && (r_pkt_count != '0)) begin
        r_pkt_count <= r_pkt_count - PTR_ONE;
      end
    end
  end

  assign data_out    = r_data_out;
  assign out_valid   = r_out_valid;
  assign sop         = r_sop;
  assign eop         = r_eop;
  assign full        = w_full;
  assign empty       = w_empty;
  assign almost_full = (r_count >= AF_LVL);
  assign count       = r_count;
  assign pkt_count   = r_pkt_count;
  assign overflow    = r_overflow;
endmodule

// File: tb/tb_router_pkt_fifo.sv
// Bench for router_pkt_fifo: queue-based reference model compared every cycle, plus directed literal checks.
module tb_router_pkt_fifo;
  localparam int DW  = 8;
  localparam int DEP = 16;
  localparam int AFT = 14;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          soft_reset = 1'b0;
  logic          write_enb = 1'b0;
  logic          lfd_state = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          read_enb = 1'b0;
  logic [DW-1:0] data_out;
  logic          out_valid, sop, eop, full, empty, almost_full, overflow;
  logic [4:0]    count, pkt_count;

  router_pkt_fifo #(.DATA_W(DW), .DEPTH(DEP), .AF_THRESH(AFT)) dut (
    .clock(clock), .reset(reset), .soft_reset(soft_reset),
    .write_enb(write_enb), .lfd_state(lfd_state), .data_in(data_in),
    .read_enb(read_enb), .data_out(data_out), .out_valid(out_valid),
    .sop(sop), .eop(eop), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count), .pkt_count(pkt_count),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [8:0] q[$];
  int         m_pc = 0, m_wrem = 0, m_rrem = 0;
  logic       m_ov = 0, m_vld = 0, m_sop = 0, m_eop = 0;
  logic [7:0] m_dout = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit         full_now, empty_now, inc, dec;
    logic [8:0] e;
    if (reset || soft_reset) begin
      q.delete();
      m_pc = 0; m_wrem = 0; m_rrem = 0; m_ov = 0;
      m_vld = 0; m_sop = 0; m_eop = 0; m_dout = '0;
      return;
    end
    full_now  = (q.size() == DEP);
    empty_now = (q.size() == 0);
    inc = 0; dec = 0;
    m_vld = 0; m_sop = 0; m_eop = 0; m_dout = '0;
    if (write_enb && full_now) m_ov = 1;
    if (read_enb && !empty_now) begin
      e = q.pop_front();
      m_vld  = 1;
      m_dout = e[7:0];
      if (e[8]) begin
        m_sop  = 1;
        m_rrem = int'(e[7:2]) + 1;
      end else if (m_rrem > 0) begin
        m_rrem--;
        if (m_rrem == 0) begin
          m_eop = 1;
          dec = 1;
        end
      end
    end
    if (write_enb && !full_now) begin
      q.push_back({lfd_state, data_in});
      if (lfd_state) m_wrem = int'(data_in[7:2]) + 1;
      else if (m_wrem > 0) begin
        m_wrem--;
        if (m_wrem == 0) inc = 1;
      end
    end
    if (inc && !dec) m_pc++;
    else if (dec && !inc && m_pc > 0) m_pc--;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic drive(input bit we, input bit lfd, input logic [7:0] d, input bit re);
    write_enb = we; lfd_state = lfd; data_in = d; read_enb = re;
    tick();
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("data_out", 32'(data_out), 32'(m_dout));
      chk("out_valid", 32'(out_valid), 32'(m_vld));
      chk("sop", 32'(sop), 32'(m_sop));
      chk("eop", 32'(eop), 32'(m_eop));
      chk("full", 32'(full), 32'(q.size() == DEP));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("almost_full", 32'(almost_full), 32'(q.size() >= AFT));
      chk("count", 32'(count), 32'(q.size()));
      chk("pkt_count", 32'(pkt_count), 32'(m_pc));
      chk("overflow", 32'(overflow), 32'(m_ov));
    end
  end

  initial begin
    logic [7:0] pkt [5];
    logic [7:0] hdr;
    pkt[0] = 8'h0C; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h44;
    chk_en = 1'b1;

    // Reset held two cycles
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_pkt_count", 32'(pkt_count), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);

    // Header 0x0C (len 3), three payload bytes, parity
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, i == 0, pkt[i], 1'b0);
      if (i == 3) chk("pkt_before_parity", 32'(pkt_count), 32'h0);
    end
    chk("pkt_after_parity", 32'(pkt_count), 32'h1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      chk("pkt_rd_data", 32'(data_out), 32'(pkt[i]));
      chk("pkt_rd_sop", 32'(sop), (i == 0) ? 32'h1 : 32'h0);
      chk("pkt_rd_eop", 32'(eop), (i == 4) ? 32'h1 : 32'h0);
    end
    chk("pkt_drained_count", 32'(pkt_count), 32'h0);
    chk("pkt_drained_empty", 32'(empty), 32'h1);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("idle_valid", 32'(out_valid), 32'h0);

    // Fill across the pointer wrap, one write beyond full
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0);
      if (i < 16) chk("fill_almost_full", 32'(almost_full), (i + 1 >= 14) ? 32'h1 : 32'h0);
      if (i == 15) chk("fill_no_overflow_yet", 32'(overflow), 32'h0);
    end
    chk("fill_full", 32'(full), 32'h1);
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_overflow", 32'(overflow), 32'h1);

    drive(1'b1, 1'b0, 8'hEE, 1'b1);
    chk("full_wr_rd_count", 32'(count), 32'd15);
    chk("full_wr_rd_data", 32'(data_out), 32'hA0);
    drive(1'b1, 1'b0, 8'hB0, 1'b1);
    chk("c15_wr_rd_count", 32'(count), 32'd15);
    chk("c15_wr_rd_data", 32'(data_out), 32'hA1);
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      chk("wrap_order", 32'(data_out), (i < 14) ? 32'(8'hA2 + 8'(i)) : 32'hB0);
    end
    chk("wrap_empty", 32'(empty), 32'h1);

    // Zero-length packet: header then parity
    drive(1'b1, 1'b1, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h5A, 1'b0);
    chk("len0_pkt_count", 32'(pkt_count), 32'h1);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    chk("len0_sop", 32'(sop), 32'h1);
    chk("len0_eop_b1", 32'(eop), 32'h0);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    chk("len0_eop_b2", 32'(eop), 32'h1);
    chk("len0_pkt_done", 32'(pkt_count), 32'h0);

    // Soft reset mid-packet, then a clean packet
    drive(1'b1, 1'b1, 8'h0C, 1'b0);
    drive(1'b1, 1'b0, 8'h01, 1'b0);
    drive(1'b1, 1'b0, 8'h02, 1'b0);
    write_enb = 1'b0;
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    chk("soft_empty", 32'(empty), 32'h1);
    chk("soft_pkt_count", 32'(pkt_count), 32'h0);
    chk("soft_overflow", 32'(overflow), 32'h0);
    drive(1'b1, 1'b1, 8'h04, 1'b0);
    drive(1'b1, 1'b0, 8'h77, 1'b0);
    drive(1'b1, 1'b0, 8'h78, 1'b0);
    chk("post_soft_pkt", 32'(pkt_count), 32'h1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      chk("post_soft_eop", 32'(eop), (i == 2) ? 32'h1 : 32'h0);
    end

    // Randomized traffic, write-heavy then read-heavy
    for (int c = 0; c < 3000; c++) begin
      int wp;
      bit we, re, lfd;
      wp  = (c < 1500) ? 70 : 40;
      we  = ($urandom_range(0, 99) < wp);
      re  = ($urandom_range(0, 99) < 100 - wp + 10);
      lfd = we && ($urandom_range(0, 99) < 15);
      hdr = {6'($urandom_range(0, 2)), 2'($urandom_range(0, 3))};
      soft_reset = ($urandom_range(0, 299) == 0);
      reset      = ($urandom_range(0, 499) == 0);
      drive(we, lfd, lfd ? hdr : 8'($urandom_range(0, 255)), re);
    end
    reset = 1'b0;
    soft_reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
